// File: rtl/self_link_fifo_buffer.sv
// Multi-stage elastic buffer for SELF valid/stop links.
// All outputs are registered; the head word is pre-fetched into an output register.
module self_link_fifo_buffer #(
    parameter int DataWidth       = 16,
    parameter int Depth           = 4,
    parameter int AlmostFullLevel = 3,
    parameter int CountWidth      = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DataWidth-1:0]  dataIn,
    input  logic                  dataInValid,
    output logic                  dataInStop,
    output logic [DataWidth-1:0]  dataOut,
    output logic                  dataOutValid,
    input  logic                  dataOutStop,
    output logic [CountWidth-1:0] fillLevel,
    output logic                  almostFull
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);
    localparam logic [CountWidth-1:0] AfCount   = CountWidth'(AlmostFullLevel);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == LastPtr) begin
            return {PtrWidth{1'b0}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    logic [DataWidth-1:0]  mem_r [Depth];
    logic [PtrWidth-1:0]   wr_ptr_r;
    logic [PtrWidth-1:0]   rd_ptr_r;
    logic [CountWidth-1:0] count_r;
    logic                  valid_r;
    logic                  stop_r;
    logic                  afull_r;
    logic [DataWidth-1:0]  dout_r;

    logic                  push_s;
    logic                  pop_s;
    logic [PtrWidth-1:0]   wr_next_s;
    logic [PtrWidth-1:0]   rd_next_s;
    logic [CountWidth-1:0] count_next_s;
    logic [DataWidth-1:0]  head_next_s;

    // Transfer decode, next pointers/occupancy and the word that will sit at the head
    always_comb begin
        push_s       = dataInValid & ~stop_r;
        pop_s        = valid_r & ~dataOutStop;
        wr_next_s    = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_next_s    = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        count_next_s = count_r + {{(CountWidth-1){1'b0}}, push_s}
                               - {{(CountWidth-1){1'b0}}, pop_s};
        // The incoming word becomes the head when the buffer would otherwise drain empty
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = dataIn;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Pointers, occupancy and registered link outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
            count_r  <= {CountWidth{1'b0}};
            valid_r  <= 1'b0;
            stop_r   <= 1'b0;
            afull_r  <= 1'b0;
            dout_r   <= {DataWidth{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CountWidth{1'b0}});
            stop_r   <= (count_next_s == FullCount);
            afull_r  <= (count_next_s >= AfCount);
            dout_r   <= head_next_s;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (!srst && push_s) begin
            mem_r[wr_ptr_r] <= dataIn;
        end
    end

    assign dataOut      = dout_r;
    assign dataOutValid = valid_r;
    assign dataInStop   = stop_r;
    assign fillLevel    = count_r;
    assign almostFull   = afull_r;

endmodule

// File: tb/tb_self_link_fifo_buffer.sv
// Self-checking bench: vector table, directed corner sequences and a queue scoreboard
// run against a Depth=4 and a Depth=5 instance.
module tb_self_link_fifo_buffer;

    logic        clk = 1'b0;
    logic        srst;
    logic [15:0] a_din, a_dout, b_din, b_dout;
    logic        a_vin, a_instop, a_vout, a_ostop, a_af;
    logic        b_vin, b_instop, b_vout, b_ostop, b_af;
    logic [2:0]  a_fill, b_fill;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    self_link_fifo_buffer #(.DataWidth(16), .Depth(4), .AlmostFullLevel(3), .CountWidth(3)) dut_a (
        .clk(clk), .srst(srst), .dataIn(a_din), .dataInValid(a_vin), .dataInStop(a_instop),
        .dataOut(a_dout), .dataOutValid(a_vout), .dataOutStop(a_ostop),
        .fillLevel(a_fill), .almostFull(a_af));

    self_link_fifo_buffer #(.DataWidth(16), .Depth(5), .AlmostFullLevel(4), .CountWidth(3)) dut_b (
        .clk(clk), .srst(srst), .dataIn(b_din), .dataInValid(b_vin), .dataInStop(b_instop),
        .dataOut(b_dout), .dataOutValid(b_vout), .dataOutStop(b_ostop),
        .fillLevel(b_fill), .almostFull(b_af));

    typedef struct {
        logic        vin;
        logic [15:0] din;
        logic        ostop;
        logic        e_vout;
        logic [15:0] e_dout;
        logic        e_instop;
        logic [2:0]  e_fill;
        logic        e_af;
    } vec_t;

    vec_t        vecs[13];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] next_a, next_b;
    int          del_a, del_b, cyc;
    logic        push_m, pop_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic vout, input logic [15:0] dout,
                               input logic instop, input logic [2:0] fill, input logic af,
                               input logic [15:0] head, input int size, input int depth,
                               input int afl);
        check({tag, "_valid"}, 32'(vout), 32'(size != 0));
        if (size != 0) check({tag, "_data"}, 32'(dout), 32'(head));
        check({tag, "_instop"}, 32'(instop), 32'(size == depth));
        check({tag, "_fill"}, 32'(fill), 32'(size));
        check({tag, "_afull"}, 32'(af), 32'(size >= afl));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 16'h00A5, 1'b0, 1'b1, 16'h00A5, 1'b0, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 16'h0001, 1'b0, 3'd2, 1'b0};
        vecs[4]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 3'd3, 1'b1};
        vecs[5]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 16'h0001, 1'b1, 3'd4, 1'b1};
        vecs[6]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 3'd4, 1'b1};
        vecs[7]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b0, 3'd3, 1'b1};
        vecs[8]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0003, 1'b0, 3'd3, 1'b1};
        vecs[9]  = '{1'b1, 16'h0006, 1'b0, 1'b1, 16'h0004, 1'b0, 3'd3, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 3'd2, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b0, 3'd1, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};

        srst = 1'b1;
        a_vin = 1'b0; a_din = 16'h0; a_ostop = 1'b0;
        b_vin = 1'b0; b_din = 16'h0; b_ostop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        check_state("rst_a", a_vout, a_dout, a_instop, a_fill, a_af, 16'h0, 0, 4, 3);
        check_state("rst_b", b_vout, b_dout, b_instop, b_fill, b_af, 16'h0, 0, 5, 4);

        // Vector table: single word, fill to full, full with simultaneous pop, drain
        for (int i = 0; i < 13; i++) begin
            a_vin = vecs[i].vin; a_din = vecs[i].din; a_ostop = vecs[i].ostop;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(a_vout), 32'(vecs[i].e_vout));
            if (vecs[i].e_vout) check($sformatf("vec%0d_data", i), 32'(a_dout), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d_instop", i), 32'(a_instop), 32'(vecs[i].e_instop));
            check($sformatf("vec%0d_fill", i), 32'(a_fill), 32'(vecs[i].e_fill));
            check($sformatf("vec%0d_afull", i), 32'(a_af), 32'(vecs[i].e_af));
        end

        // Reset mid-operation with a word presented during reset
        a_ostop = 1'b1; a_vin = 1'b1;
        a_din = 16'h0011; tick();
        a_din = 16'h0022; tick();
        a_din = 16'h0033; tick();
        check("pre_rst_fill", 32'(a_fill), 32'd3);
        srst = 1'b1; a_din = 16'hBEEF;
        tick();
        srst = 1'b0; a_vin = 1'b0;
        check_state("post_rst", a_vout, a_dout, a_instop, a_fill, a_af, 16'h0, 0, 4, 3);
        tick();
        check_state("post_rst2", a_vout, a_dout, a_instop, a_fill, a_af, 16'h0, 0, 4, 3);
        a_vin = 1'b1; a_din = 16'h0777; a_ostop = 1'b0;
        tick();
        a_vin = 1'b0;
        check_state("after_rst_push", a_vout, a_dout, a_instop, a_fill, a_af, 16'h0777, 1, 4, 3);
        tick();
        check("after_rst_drain", 32'(a_vout), 32'd0);

        // Head word held under downstream stop
        a_ostop = 1'b1; a_vin = 1'b1; a_din = 16'h1234; tick();
        a_din = 16'h5678; tick();
        a_vin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d_valid", i), 32'(a_vout), 32'd1);
            check($sformatf("hold%0d_data", i), 32'(a_dout), 32'h1234);
            check($sformatf("hold%0d_fill", i), 32'(a_fill), 32'd2);
        end
        a_ostop = 1'b0;
        tick();
        check("release_data", 32'(a_dout), 32'h5678);
        check("release_fill", 32'(a_fill), 32'd1);
        tick();
        check("release_empty", 32'(a_vout), 32'd0);

        // Random downstream stop with scoreboards on both depths
        void'($urandom(32'd2024));
        next_a = 16'h0001; next_b = 16'h0001;
        del_a = 0; del_b = 0; cyc = 0;
        while ((del_a < 1000 || del_b < 1000) && cyc < 20000 && n_errors < 50) begin
            check_state("rnd_a", a_vout, a_dout, a_instop, a_fill, a_af,
                        (qa.size() != 0) ? qa[0] : 16'h0, qa.size(), 4, 3);
            check_state("rnd_b", b_vout, b_dout, b_instop, b_fill, b_af,
                        (qb.size() != 0) ? qb[0] : 16'h0, qb.size(), 5, 4);

            a_vin = 1'b1; a_din = next_a; a_ostop = ($urandom_range(0, 99) < 40);
            b_vin = 1'b1; b_din = next_b; b_ostop = ($urandom_range(0, 99) < 45);

            push_m = (qa.size() != 4);
            pop_m  = !a_ostop && (qa.size() != 0);
            if (pop_m) begin
                check("rnd_a_pop", 32'(a_dout), 32'(qa.pop_front()));
                del_a++;
            end
            if (push_m) begin
                qa.push_back(next_a);
                next_a = next_a + 16'h0001;
            end

            push_m = (qb.size() != 5);
            pop_m  = !b_ostop && (qb.size() != 0);
            if (pop_m) begin
                check("rnd_b_pop", 32'(b_dout), 32'(qb.pop_front()));
                del_b++;
            end
            if (push_m) begin
                qb.push_back(next_b);
                next_b = next_b + 16'h0001;
            end

            tick();
            cyc++;
        end
        check("rnd_a_delivered", 32'(del_a >= 1000), 32'd1);
        check("rnd_b_delivered", 32'(del_b >= 1000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/self_link_fifo_buffer.md
Name: self_link_fifo_buffer

Overview:
Parametrised multi-stage elastic buffer for SELF valid/stop links. It is the successor to the single-stage SELF toggle buffer. It decouples upstream and downstream by up to Depth words and adds occupancy and almost-full reporting. All outputs are registered, so the block can be dropped onto any SELF link to break timing paths in both the data and stop directions.

Parameters:
DataWidth, 16, width of dataIn/dataOut in bits (>=1)
Depth, 4, number of storage entries (>=2; need not be a power of two)
AlmostFullLevel, 3, occupancy at or above which almostFull asserts (1..Depth)
CountWidth, 3, width of fillLevel; must satisfy 2^CountWidth > Depth

Ports:
clk  input  1  system clock; all logic on rising edge
srst  input  1  synchronous reset, active high
dataIn  input  DataWidth  upstream data word
dataInValid  input  1  upstream word present
dataInStop  output  1  high = buffer refuses upstream word this cycle
dataOut  output  DataWidth  downstream data word (head of queue)
dataOutValid  output  1  head word present
dataOutStop  input  1  high = downstream refuses head word this cycle
fillLevel  output  CountWidth  number of stored words, 0..Depth
almostFull  output  1  high when fillLevel >= AlmostFullLevel

Behaviour:
- SELF transfer rule: a word moves on a rising edge iff valid=1 and stop=0 in that cycle. Push = dataInValid & ~dataInStop. Pop = dataOutValid & ~dataOutStop.
- Reset (srst=1 at an edge): read/write pointers=0, fillLevel=0, dataOutValid=0, dataInStop=0, almostFull=0. dataOut is don't-care. Reset mid-operation discards all stored words with no further transfers. srst dominates push/pop in the same cycle.
- Storage: circular array of Depth entries. Write pointer advances on push, read pointer on pop. Each pointer wraps from Depth-1 to 0.
- dataOutValid = (fillLevel != 0), registered. dataOut = entry at read pointer, registered or read from register array, stable while dataOutValid=1 and dataOutStop=1.
- dataInStop = (fillLevel == Depth), registered. There is no combinational path from dataOutStop to dataInStop or from dataInValid to dataOutValid.
- Latency: a word pushed into an empty buffer appears with dataOutValid=1 on the next cycle (1-cycle latency, no fall-through).
- fillLevel next = fillLevel + push - pop. Simultaneous push and pop leave it unchanged and advance both pointers.
- Full: dataInStop=1. No push occurs even if a pop happens in the same cycle. dataInStop deasserts the cycle after the pop.
- Empty: dataOutValid=0. A pop cannot occur. dataOutStop is ignored.
- almostFull is derived from the next-state fillLevel and registered alongside it.
- Words are delivered in order, with no loss or duplication, under any stop/valid pattern.
- dataInValid may drop without a transfer. The upstream SELF rule requires the word to be held, but the buffer does not check this.

Test Plan:
- Reset then single word 0x00A5 with dataOutStop=0 -> dataOutValid=1, dataOut=0x00A5 exactly 1 cycle later. fillLevel goes 0->1->0. Stops stay 0.
- Depth=4, dataOutStop=1, push 0x1..0x6 continuously -> 4 accepted. dataInStop=1 from the cycle after the 4th push. almostFull=1 once fillLevel=3. Release stop -> outputs 0x1,0x2,0x3,0x4, then 0x5,0x6 in order.
- Full buffer, dataInValid=1 and dataOutStop=0 in the same cycle -> pop of head only, fillLevel 4->3. The input is accepted on the next cycle.
- Continuous valid=1 on both sides with a random dataOutStop pattern over 1000 words (seed-fixed) -> scoreboard shows in-order, lossless delivery, and fillLevel never exceeds 4. Pointer wrap is exercised; also run with Depth=5 to cover non-power-of-two.
- Fill with 3 words, assert srst for 1 cycle with dataInValid=1 -> next cycle fillLevel=0, dataOutValid=0, dataInStop=0. The word presented during reset is not stored.
- Hold head word with dataOutStop=1 for 10 cycles -> dataOut and dataOutValid are unchanged throughout.
